// File: rtl/core_pkg.sv
// Shared core types: s1 fetch interface, read-only LIMP port and icache FSM states.
package core_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        valid;
    } mmu_instr_req_s;

    typedef struct packed {
        logic [31:0] instr;
        logic        ready;
        logic        illegal;
    } mmu_instr_rsp_s;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } limp_rd_req_s;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        illegal;
    } limp_rd_rsp_s;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        FAULT
    } icache_state_e;

endpackage

// File: rtl/core_icache_array.sv
// Valid/tag/data storage for the direct-mapped icache: combinational lookup,
// synchronous word/tag write and line or whole-cache invalidation.
module core_icache_array #(
    parameter  int NUM_LINES  = 16,
    parameter  int LINE_WORDS = 4,
    parameter  int TAG_BITS   = 24,
    localparam int LINE_BITS  = $clog2(NUM_LINES),
    localparam int WORD_BITS  = $clog2(LINE_WORDS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [LINE_BITS-1:0] i_rd_line,
    input  logic [WORD_BITS-1:0] i_rd_word,
    input  logic [TAG_BITS-1:0]  i_rd_tag,
    output logic                 o_hit,
    output logic [31:0]          o_rd_data,
    input  logic                 i_inval_all,
    input  logic                 i_inval_line_en,
    input  logic                 i_wr_en,
    input  logic [LINE_BITS-1:0] i_wr_line,
    input  logic [WORD_BITS-1:0] i_wr_word,
    input  logic [31:0]          i_wr_data,
    input  logic                 i_tag_we,
    input  logic [TAG_BITS-1:0]  i_tag,
    input  logic                 i_tag_valid
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES][LINE_WORDS];

    assign o_hit     = valid[i_rd_line] && (tag_mem[i_rd_line] == i_rd_tag);
    assign o_rd_data = data_mem[i_rd_line][i_rd_word];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid <= '0;
        end else if (i_inval_all) begin
            valid <= '0;
        end else begin
            if (i_inval_line_en) valid[i_rd_line] <= 1'b0;
            if (i_tag_we)        valid[i_wr_line] <= i_tag_valid;
        end
    end

    // NOTE: tag/data flops have no reset; the valid bits alone decide whether their contents are used.
    always_ff @(posedge i_clk) begin
        if (i_wr_en)  data_mem[i_wr_line][i_wr_word] <= i_wr_data;
        if (i_tag_we) tag_mem[i_wr_line] <= i_tag;
    end

endmodule

// File: rtl/core_icache.sv
// Direct-mapped read-only instruction cache between s1 and the memory arbiter;
// misses refill one word per beat over a LIMP read port, FENCE.I flushes all lines.
module core_icache
    import core_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  mmu_instr_req_s i_instr_req,
    output mmu_instr_rsp_s o_instr_rsp,
    input  logic           i_flush,
    output logic           o_limp_valid,
    output logic [31:0]    o_limp_addr,
    input  logic           i_limp_ready,
    input  logic [31:0]    i_limp_rdata,
    input  logic           i_limp_illegal
);

    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int LINE_BITS = $clog2(NUM_LINES);
    localparam int OFF_BITS  = 2 + WORD_BITS;
    localparam int TAG_LO    = OFF_BITS + LINE_BITS;
    localparam int TAG_BITS  = 32 - TAG_LO;

    icache_state_e        state;
    mmu_instr_rsp_s       rsp_q;
    limp_rd_req_s         limp_q;
    limp_rd_rsp_s         limp_rsp;
    logic [WORD_BITS-1:0] beat_cnt;
    logic                 flush_pending;
    logic [LINE_BITS-1:0] fill_line;
    logic [TAG_BITS-1:0]  fill_tag;

    logic [WORD_BITS-1:0] req_word;
    logic [LINE_BITS-1:0] req_line;
    logic [TAG_BITS-1:0]  req_tag;
    logic                 misaligned;
    logic                 flush_now;
    logic                 hit;
    logic [31:0]          rd_data;
    logic                 lookup_miss;
    logic                 beat_ok;
    logic                 last_beat;
    logic                 fault_match;

    assign limp_rsp   = '{ready: i_limp_ready, rdata: i_limp_rdata, illegal: i_limp_illegal};
    assign req_word   = i_instr_req.addr[OFF_BITS-1:2];
    assign req_line   = i_instr_req.addr[TAG_LO-1:OFF_BITS];
    assign req_tag    = i_instr_req.addr[31:TAG_LO];
    assign misaligned = i_instr_req.addr[1:0] != 2'b00;

    assign flush_now   = (state == IDLE) && (i_flush || flush_pending);
    assign lookup_miss = (state == IDLE) && !flush_now && i_instr_req.valid && !misaligned && !hit;
    assign beat_ok     = (state == REFILL) && limp_rsp.ready && !limp_rsp.illegal;
    assign last_beat   = beat_ok && (&beat_cnt);
    // Only a request to the block whose refill faulted gets the illegal response.
    assign fault_match = i_instr_req.valid && (i_instr_req.addr[31:OFF_BITS] == {fill_tag, fill_line});

    core_icache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_rd_line       (req_line),
        .i_rd_word       (req_word),
        .i_rd_tag        (req_tag),
        .o_hit           (hit),
        .o_rd_data       (rd_data),
        .i_inval_all     (flush_now),
        .i_inval_line_en (lookup_miss),
        .i_wr_en         (beat_ok),
        .i_wr_line       (fill_line),
        .i_wr_word       (beat_cnt),
        .i_wr_data       (limp_rsp.rdata),
        .i_tag_we        (last_beat),
        .i_tag           (fill_tag),
        .i_tag_valid     (!flush_pending)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            rsp_q         <= '0;
            limp_q        <= '0;
            beat_cnt      <= '0;
            flush_pending <= 1'b0;
            fill_line     <= '0;
            fill_tag      <= '0;
        end else begin
            rsp_q <= '0;
            case (state)
                IDLE: begin
                    if (i_flush || flush_pending) begin
                        flush_pending <= 1'b0;
                    end else if (i_instr_req.valid && misaligned) begin
                        rsp_q <= '{instr: 32'd0, ready: 1'b1, illegal: 1'b1};
                    end else if (i_instr_req.valid && hit) begin
                        rsp_q <= '{instr: rd_data, ready: 1'b1, illegal: 1'b0};
                    end else if (i_instr_req.valid) begin
                        fill_line <= req_line;
                        fill_tag  <= req_tag;
                        beat_cnt  <= '0;
                        limp_q    <= '{valid: 1'b1,
                                       addr:  {i_instr_req.addr[31:OFF_BITS], {OFF_BITS{1'b0}}}};
                        state     <= REFILL;
                    end
                end
                REFILL: begin
                    if (i_flush) flush_pending <= 1'b1;
                    if (limp_rsp.ready) begin
                        if (limp_rsp.illegal) begin
                            limp_q   <= '0;
                            beat_cnt <= '0;
                            state    <= FAULT;
                        end else if (&beat_cnt) begin
                            limp_q   <= '0;
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt    <= beat_cnt + 1'b1;
                            limp_q.addr <= limp_q.addr + 32'd4;
                        end
                    end
                end
                FAULT: begin
                    if (i_flush) flush_pending <= 1'b1;
                    if (fault_match) rsp_q <= '{instr: 32'd0, ready: 1'b1, illegal: 1'b1};
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_instr_rsp  = rsp_q;
    assign o_limp_valid = limp_q.valid;
    assign o_limp_addr  = limp_q.addr;

endmodule

// File: tb/tb_core_icache.sv
// Self-checking bench for core_icache: directed scenarios plus randomized fetches
// checked against a line-level cache model and an address-hash memory.
module tb_core_icache;
    import core_pkg::*;

    localparam int NUM_LINES  = 16;
    localparam int LINE_WORDS = 4;
    localparam int LINE_BYTES = 4 * LINE_WORDS;

    logic           i_clk = 1'b0;
    logic           i_rst;
    mmu_instr_req_s i_instr_req;
    mmu_instr_rsp_s o_instr_rsp;
    logic           i_flush;
    logic           o_limp_valid;
    logic [31:0]    o_limp_addr;
    logic           i_limp_ready;
    logic [31:0]    i_limp_rdata;
    logic           i_limp_illegal;

    core_icache #(.NUM_LINES(NUM_LINES), .LINE_WORDS(LINE_WORDS)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_instr_req    (i_instr_req),
        .o_instr_rsp    (o_instr_rsp),
        .i_flush        (i_flush),
        .o_limp_valid   (o_limp_valid),
        .o_limp_addr    (o_limp_addr),
        .i_limp_ready   (i_limp_ready),
        .i_limp_rdata   (i_limp_rdata),
        .i_limp_illegal (i_limp_illegal)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory contents are a fixed hash of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A17_C3E1;
    endfunction

    // Reference model: which block each line currently holds.
    bit          model_valid [NUM_LINES];
    logic [31:0] model_base  [NUM_LINES];

    function automatic int line_of(input logic [31:0] a);
        return int'((a / LINE_BYTES) % NUM_LINES);
    endfunction

    task automatic model_invalidate_all();
        for (int i = 0; i < NUM_LINES; i++) model_valid[i] = 1'b0;
    endtask

    // LIMP responder / stimulus state
    logic [31:0] beats[$];
    int          stalls;
    bit          stall_en   = 1'b0;
    bit          flush_arm  = 1'b0;
    logic [31:0] fault_addr = 32'h1;

    // One clock: outputs are observed at the negedge and inputs for the next edge are set then.
    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
        i_flush = 1'b0;
        if (flush_arm && o_limp_valid && beats.size() >= 1) begin
            i_flush   = 1'b1;
            flush_arm = 1'b0;
        end
        i_limp_ready   = o_limp_valid && (!stall_en || $urandom_range(3) != 0);
        i_limp_rdata   = i_limp_ready ? mem_word(o_limp_addr) : 32'd0;
        i_limp_illegal = i_limp_ready && (o_limp_addr == fault_addr);
        if (o_limp_valid && !i_limp_ready) stalls++;
        if (i_limp_ready) beats.push_back(o_limp_addr);
    endtask

    // Present one fetch and compare its response, latency and refill beats with the model.
    task automatic fetch(input logic [31:0] addr, input int fault_word, input bit do_flush);
        logic [31:0] exp_instr;
        logic        exp_illegal;
        logic [31:0] exp_beats[$];
        logic [31:0] base;
        int          lat;
        int          ln;
        int          n;

        base = addr & ~(LINE_BYTES - 1);
        ln   = line_of(addr);
        exp_beats.delete();
        if (addr[1:0] != 2'b00) begin
            exp_instr = 32'd0; exp_illegal = 1'b1; lat = 1;
        end else if (model_valid[ln] && model_base[ln] == base) begin
            exp_instr = mem_word(addr); exp_illegal = 1'b0; lat = 1;
        end else if (fault_word >= 0) begin
            for (int w = 0; w <= fault_word; w++) exp_beats.push_back(base + 4 * w);
            exp_instr       = 32'd0;
            exp_illegal     = 1'b1;
            lat             = fault_word + 3;
            model_valid[ln] = 1'b0;
            fault_addr      = base + 4 * fault_word;
        end else begin
            for (int w = 0; w < LINE_WORDS; w++) exp_beats.push_back(base + 4 * w);
            lat = LINE_WORDS + 2;
            if (do_flush) begin
                // flushed refill leaves the line invalid, so the re-lookup refills again
                for (int w = 0; w < LINE_WORDS; w++) exp_beats.push_back(base + 4 * w);
                lat       = 2 * LINE_WORDS + 4;
                flush_arm = 1'b1;
                model_invalidate_all();
            end
            exp_instr       = mem_word(addr);
            exp_illegal     = 1'b0;
            model_valid[ln] = 1'b1;
            model_base[ln]  = base;
        end

        beats.delete();
        stalls      = 0;
        i_instr_req = '{addr: addr, valid: 1'b1};
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (o_instr_rsp.ready) break;
        end
        check($sformatf("ready@%08h", addr), o_instr_rsp.ready, 1'b1);
        if (o_instr_rsp.ready) begin
            check($sformatf("instr@%08h", addr), o_instr_rsp.instr, exp_instr);
            check($sformatf("illegal@%08h", addr), o_instr_rsp.illegal, exp_illegal);
            check($sformatf("latency@%08h", addr), n, lat + stalls);
            check($sformatf("beat_count@%08h", addr), beats.size(), exp_beats.size());
            for (int i = 0; i < beats.size() && i < exp_beats.size(); i++)
                check($sformatf("beat%0d@%08h", i, addr), beats[i], exp_beats[i]);
        end
        fault_addr = 32'h1;
        flush_arm  = 1'b0;
    endtask

    task automatic idle();
        i_instr_req = '0;
        tick();
        check("idle_ready", o_instr_rsp.ready, 1'b0);
        check("idle_limp_valid", o_limp_valid, 1'b0);
    endtask

    task automatic flush_idle();
        i_instr_req = '0;
        i_flush     = 1'b1;
        tick();
        model_invalidate_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          fw;
        bit          fl;

        i_rst          = 1'b1;
        i_instr_req    = '0;
        i_flush        = 1'b0;
        i_limp_ready   = 1'b0;
        i_limp_rdata   = '0;
        i_limp_illegal = 1'b0;
        model_invalidate_all();
        repeat (2) @(negedge i_clk);
        check("rst_ready", o_instr_rsp.ready, 1'b0);
        check("rst_instr", o_instr_rsp.instr, 32'd0);
        check("rst_illegal", o_instr_rsp.illegal, 1'b0);
        check("rst_limp_valid", o_limp_valid, 1'b0);
        check("rst_limp_addr", o_limp_addr, 32'd0);
        i_rst = 1'b0;

        // cold miss, then back-to-back hits on the filled line
        fetch(32'h0000_0104, -1, 1'b0);
        fetch(32'h0000_0100, -1, 1'b0);
        fetch(32'h0000_0104, -1, 1'b0);
        fetch(32'h0000_0108, -1, 1'b0);
        idle();

        // misaligned
        fetch(32'h0000_0102, -1, 1'b0);
        idle();

        // conflict eviction
        fetch(32'h0000_0200, -1, 1'b0);
        fetch(32'h0000_0100, -1, 1'b0);
        idle();

        // refill fault on beat 2, then a clean re-refill
        fetch(32'h0000_0300, 2, 1'b0);
        idle();
        fetch(32'h0000_0300, -1, 1'b0);
        idle();

        // flush mid-refill
        fetch(32'h0000_0200, -1, 1'b0);
        fetch(32'h0000_0100, -1, 1'b1);
        idle();

        // asynchronous reset during refill
        flush_idle();
        i_instr_req = '{addr: 32'h0000_0100, valid: 1'b1};
        tick();
        check("pre_rst_limp_valid", o_limp_valid, 1'b1);
        i_rst = 1'b1;
        #1;
        check("mid_rst_limp_valid", o_limp_valid, 1'b0);
        check("mid_rst_limp_addr", o_limp_addr, 32'd0);
        check("mid_rst_ready", o_instr_rsp.ready, 1'b0);
        check("mid_rst_instr", o_instr_rsp.instr, 32'd0);
        i_instr_req  = '0;
        i_limp_ready = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        model_invalidate_all();
        fetch(32'h0000_0100, -1, 1'b0);
        idle();

        // randomized traffic with LIMP stalls, faults and mid-refill flushes
        for (int it = 0; it < 150; it++) begin
            a = 32'($urandom_range(0, 255)) * 32'd4;
            if ($urandom_range(11) == 0) a[1:0] = 2'($urandom_range(1, 3));
            stall_en = 1'($urandom_range(1));
            fw = ($urandom_range(9) == 0) ? int'($urandom_range(LINE_WORDS - 1)) : -1;
            fl = (fw < 0) && ($urandom_range(9) == 0);
            fetch(a, fw, fl);
            if ($urandom_range(3) == 0) idle();
            if ($urandom_range(19) == 0) flush_idle();
        end
        stall_en = 1'b0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_icache.md
Name: core_icache

Overview:
- Responder end of the s1 instruction-fetch interface: accepts core_pkg::mmu_instr_req_s from s1 and returns core_pkg::mmu_instr_rsp_s.
- Direct-mapped, read-only, flop-based instruction cache.
- Misses are refilled one word per beat over a LIMP-style read port toward the memory system.
- Sits between s1 and the core's memory arbiter; supports full invalidation for FENCE.I.

Parameters:
- NUM_LINES, 16, number of cache lines; power of two, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
- i_clk  in  1  core clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_instr_req  in  $bits(mmu_instr_req_s)  fetch request from s1 (addr, valid).
- o_instr_rsp  out  $bits(mmu_instr_rsp_s)  fetch response to s1 (instr, ready, illegal).
- i_flush  in  1  one-cycle pulse; invalidate all lines.
- o_limp_valid  out  1  refill read request valid.
- o_limp_addr  out  32  refill word address, word-aligned.
- i_limp_ready  in  1  refill beat complete; rdata and illegal are valid this cycle.
- i_limp_rdata  in  32  refill read data.
- i_limp_illegal  in  1  access fault on this beat.

Behaviour:
- Clock and reset: one clock (i_clk). Reset (i_rst) is asynchronous and active-high.
- Reset values: state IDLE; all line valid bits 0; o_instr_rsp all zero; o_limp_valid 0; o_limp_addr 0; beat counter 0; flush_pending 0. Tag and data arrays are not reset.
- Address split: [1:0] byte offset; next log2(LINE_WORDS) bits are the word index; next log2(NUM_LINES) bits are the line index; the remaining upper bits are the tag. Defaults: word [3:2], line [7:4], tag [31:8].
- Response outputs are registered. rsp.ready is a one-cycle pulse. instr and illegal are meaningful only while ready=1; otherwise they are 0.
- Handshake:
  - s1 holds req.valid and req.addr stable until it sees rsp.ready.
  - In the rsp.ready cycle, the sampled request is a new request. This gives back-to-back hits at one instruction per cycle.
  - s1 may drop or change the request at any time, e.g. on a branch. Only the request present in the IDLE lookup cycle gets a response.
- State IDLE, evaluated each cycle in this priority order:
  1. i_flush or flush_pending: clear all valid bits and flush_pending; no response next cycle.
  2. req.valid and addr[1:0] != 0: next cycle ready=1, illegal=1, instr=0. No refill.
  3. req.valid and hit (line valid, tags equal): next cycle ready=1, instr = stored word.
  4. req.valid and miss: latch line base address, clear the line's valid bit, counter=0, go to REFILL. No response.
  5. Otherwise stay in IDLE.
- State REFILL:
  - o_limp_valid=1 and o_limp_addr = line base + 4*counter. Both are held stable until i_limp_ready.
  - On i_limp_ready with i_limp_illegal=0: write i_limp_rdata to data[line][counter] and increment counter.
  - On the last beat: write the tag, set valid only if flush_pending=0, go to IDLE.
  - On i_limp_ready with i_limp_illegal=1: abort, line stays invalid, go to FAULT.
  - Refill order is word 0 upward; there is no critical-word-first.
- State FAULT (one cycle):
  - If req.valid and req.addr maps to the faulting line base: next cycle ready=1, illegal=1, instr=0.
  - Go to IDLE.
- Miss latency with i_limp_ready always high:
  - Cycle 0: miss detected.
  - Cycles 1..LINE_WORDS: beats.
  - Cycle LINE_WORDS+1: IDLE re-lookup hits.
  - Cycle LINE_WORDS+2: ready=1.
- i_flush outside IDLE sets flush_pending. The flush is applied on the first IDLE cycle.
- Reset mid-refill drops o_limp_valid immediately (asynchronous) and invalidates all lines.
- The cache never issues writes and never abandons a LIMP beat once o_limp_valid is asserted.

Decomposition:
- Add to core_pkg: icache_state_e {IDLE, REFILL, FAULT}.
- Add to core_pkg: LIMP request and response structs for a read-only port (valid/addr and ready/rdata/illegal) so the arbiter can reuse them.
- Compute address-split widths locally from the parameters.
- One sub-module is natural: core_icache_array (valid, tag and data flops, with combinational hit/read and a synchronous write port). The FSM stays in core_icache.

Test Plan:
- Cold miss: req addr=0x00000104, i_limp_ready always 1.
  - o_limp_addr must be 0x100, 0x104, 0x108, 0x10C on cycles 1-4.
  - ready=1 with the 0x104 word on cycle 6.
- Back-to-back hits: after filling 0x100-0x10C, present 0x100, 0x104, 0x108 on consecutive ready cycles.
  - Three consecutive ready pulses return the correct words; there is no LIMP activity.
- Misaligned: req addr=0x00000102.
  - Next cycle ready=1, illegal=1, instr=0, o_limp_valid stays 0.
- Conflict eviction: fill 0x100, then request 0x200 (same line index, tag 0x2).
  - Refill runs, then a request to 0x100 misses again.
- Refill fault: i_limp_illegal=1 on beat 2 of the 0x300 refill.
  - Response is ready=1, illegal=1.
  - A later request to 0x300 re-issues a refill starting at 0x300.
- Flush: pulse i_flush mid-refill of 0x100.
  - Refill completes but the line stays invalid, and the next request to 0x100 misses.
  - Also assert i_rst during REFILL: o_limp_valid drops in the same cycle and all outputs read zero.
